// File: rtl/alu_seq.sv
// Sequenced relay-style ALU: captures operands on start, settles, then drives the result until ack.
// Optional RELAY_SETTLE_EN macro enables the SETTLE state and its settle counter.
module alu_seq #(
    parameter int unsigned SETTLE = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] b,
    input  logic [7:0] c,
    input  logic [2:0] fn,
    input  logic       start,
    input  logic       ack,
    output logic       busy,
    output logic       result_oe,
    output logic [7:0] result,
    output logic       zero,
    output logic       carry,
    output logic       sign,
    output logic       led_alu
);

    localparam int unsigned DW = 8;
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DRIVE  = 2'd2
    } state_t;

    state_t         state;
    state_t         next_state;
    logic [DW:0]    sum;
    logic [DW-1:0]  op_b;
    logic [DW-1:0]  op_c;
    logic [2:0]     op_fn;
    logic           enter_drive;

    // Bit DW is the carry; only ADD and INC can set it.
    function automatic logic [DW:0] alu_calc(input logic [2:0] f, input logic [DW-1:0] x,
                                             input logic [DW-1:0] y);
        logic [DW:0] r;
        r = '0;
        case (f)
            3'b000:  r = {1'b0, x} + {1'b0, y};
            3'b001:  r = {1'b0, x} + (DW+1)'(1);
            3'b010:  r = {1'b0, x & y};
            3'b011:  r = {1'b0, x | y};
            3'b100:  r = {1'b0, x ^ y};
            3'b101:  r = {1'b0, ~x};
            3'b110:  r = {1'b0, x[DW-2:0], x[DW-1]};
            default: r = '0;
        endcase
        return r;
    endfunction

`ifdef RELAY_SETTLE_EN
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_next;
    logic [DW-1:0]  b_q;
    logic [DW-1:0]  c_q;
    logic [2:0]     fn_q;

    // Result is formed from the operands frozen at the start edge.
    always_comb begin
        op_b  = b_q;
        op_c  = c_q;
        op_fn = fn_q;
    end
`else
    logic [CW-1:0]  unused_settle;

    assign unused_settle = CW'(SETTLE);

    // Without settling, DRIVE is entered on the start edge itself, so use live operands.
    always_comb begin
        op_b  = b;
        op_c  = c;
        op_fn = fn;
    end
`endif

    always_comb begin
        next_state = state;
`ifdef RELAY_SETTLE_EN
        cnt_next   = cnt;
`endif
        case (state)
            ST_IDLE: begin
                if (start) begin
`ifdef RELAY_SETTLE_EN
                    next_state = ST_SETTLE;
                    cnt_next   = CW'(SETTLE - 1);
`else
                    next_state = ST_DRIVE;
`endif
                end
            end
            ST_SETTLE: begin
`ifdef RELAY_SETTLE_EN
                if (cnt == '0) begin
                    next_state = ST_DRIVE;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
`else
                next_state = ST_IDLE;
`endif
            end
            ST_DRIVE: begin
                if (ack) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
        sum         = alu_calc(op_fn, op_b, op_c);
        enter_drive = (state != ST_DRIVE) && (next_state == ST_DRIVE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            led_alu   <= 1'b0;
            result_oe <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            carry     <= 1'b0;
            sign      <= 1'b0;
`ifdef RELAY_SETTLE_EN
            cnt       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            fn_q      <= '0;
`endif
        end else begin
            state     <= next_state;
            busy      <= (next_state != ST_IDLE);
            led_alu   <= (next_state != ST_IDLE);
            result_oe <= (next_state == ST_DRIVE);
`ifdef RELAY_SETTLE_EN
            cnt       <= cnt_next;
            if (state == ST_IDLE && start) begin
                b_q  <= b;
                c_q  <= c;
                fn_q <= fn;
            end
`endif
            // Flags persist across ack; only the bus value is released.
            if (enter_drive) begin
                result <= sum[DW-1:0];
                carry  <= sum[DW];
                zero   <= (sum[DW-1:0] == '0);
                sign   <= sum[DW-1];
            end else if (next_state != ST_DRIVE) begin
                result <= '0;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq; adapts expected latency to RELAY_SETTLE_EN.
module tb_alu_seq;

    localparam int unsigned SETTLE = 3;
`ifdef RELAY_SETTLE_EN
    localparam int LAT = SETTLE + 1;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] b = 8'h00;
    logic [7:0] c = 8'h00;
    logic [2:0] fn = 3'b000;
    logic       start = 1'b0;
    logic       ack = 1'b0;
    logic       busy, result_oe, zero, carry, sign, led_alu;
    logic [7:0] result;

    int compared = 0;
    int mismatched = 0;

    alu_seq #(.SETTLE(SETTLE)) dut (
        .clk(clk), .rst(rst), .b(b), .c(c), .fn(fn), .start(start), .ack(ack),
        .busy(busy), .result_oe(result_oe), .result(result),
        .zero(zero), .carry(carry), .sign(sign), .led_alu(led_alu)
    );

    always #5 clk = ~clk;

    // Status word: {busy, led_alu, result_oe, result, carry, zero, sign}
    function automatic logic [13:0] st();
        return {busy, led_alu, result_oe, result, carry, zero, sign};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start and count edges (start edge = 1) until result_oe rises, bounded.
    task automatic issue(input logic [2:0] f, input logic [7:0] bv, input logic [7:0] cv,
                         output int lat);
        fn = f; b = bv; c = cv; start = 1'b1;
        lat = 0;
        do begin
            tick();
            start = 1'b0;
            lat++;
        end while (!result_oe && lat < 20);
        if (!result_oe) lat = 99;
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        b = 8'hA5; c = 8'h5A; start = 1'b1;
        tick();
        compared++;
        if (st() !== 14'h0000) begin
            mismatched++;
            $display("FAIL reset_state: got %h want %h", st(), 14'h0000);
        end
        start = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_add_sign();
        int lat;
        issue(3'b000, 8'h7F, 8'h01, lat);
        compared++;
        if (lat !== LAT) begin
            mismatched++;
            $display("FAIL add_sign_latency: got %0d want %0d", lat, LAT);
        end
        compared++;
        if (st() !== {3'b111, 8'h80, 3'b001}) begin
            mismatched++;
            $display("FAIL add_sign_result: got %h want %h", st(), {3'b111, 8'h80, 3'b001});
        end
        do_ack();
        compared++;
        if (st() !== {3'b000, 8'h00, 3'b001}) begin
            mismatched++;
            $display("FAIL add_sign_after_ack: got %h want %h", st(), {3'b000, 8'h00, 3'b001});
        end
    endtask

    task automatic test_add_carry();
        int lat;
        issue(3'b000, 8'hFF, 8'h01, lat);
        compared++;
        if (st() !== {3'b111, 8'h00, 3'b110}) begin
            mismatched++;
            $display("FAIL add_carry_result: got %h want %h", st(), {3'b111, 8'h00, 3'b110});
        end
        do_ack();
        compared++;
        if (st() !== {3'b000, 8'h00, 3'b110}) begin
            mismatched++;
            $display("FAIL add_carry_flags_held: got %h want %h", st(), {3'b000, 8'h00, 3'b110});
        end
    endtask

    task automatic test_shl_xor();
        int lat;
        issue(3'b110, 8'h81, 8'hFF, lat);
        compared++;
        if (st() !== {3'b111, 8'h03, 3'b000}) begin
            mismatched++;
            $display("FAIL shl_rotate: got %h want %h", st(), {3'b111, 8'h03, 3'b000});
        end
        do_ack();
        issue(3'b100, 8'hAA, 8'hFF, lat);
        compared++;
        if (st() !== {3'b111, 8'h55, 3'b000}) begin
            mismatched++;
            $display("FAIL xor_result: got %h want %h", st(), {3'b111, 8'h55, 3'b000});
        end
        do_ack();
    endtask

    task automatic test_functions();
        logic [2:0] fv [5] = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b111};
        logic [7:0] bv [5] = '{8'hFF, 8'hF0, 8'h0F, 8'h5A, 8'hFF};
        logic [7:0] cv [5] = '{8'h00, 8'h3C, 8'h30, 8'hFF, 8'hFF};
        logic [7:0] rv [5] = '{8'h00, 8'h30, 8'h3F, 8'hA5, 8'h00};
        logic [2:0] flv [5] = '{3'b110, 3'b000, 3'b000, 3'b001, 3'b010};
        int lat;
        for (int i = 0; i < 5; i++) begin
            issue(fv[i], bv[i], cv[i], lat);
            compared++;
            if (st() !== {3'b111, rv[i], flv[i]}) begin
                mismatched++;
                $display("FAIL func_%0d fn=%b: got %h want %h", i, fv[i], st(), {3'b111, rv[i], flv[i]});
            end
            do_ack();
        end
    endtask

    task automatic test_back_to_back();
        int n;
        logic bad;
        fn = 3'b010; b = 8'hF0; c = 8'h3C; start = 1'b1;
        tick();
        start = 1'b0;
        compared++;
        if ({busy, result_oe, result} !== {1'b1, (LAT == 1), (LAT == 1) ? 8'h30 : 8'h00}) begin
            mismatched++;
            $display("FAIL b2b_first_edge: got %b%b %h", busy, result_oe, result);
        end
        // Disturb operands and re-pulse start while the operation is in flight.
        fn = 3'b100; b = 8'h11; c = 8'h22; start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!result_oe && n < 20) begin
            tick();
            n++;
        end
        compared++;
        if ({result_oe, result} !== {1'b1, 8'h30}) begin
            mismatched++;
            $display("FAIL b2b_result: got oe=%b %h want oe=1 30", result_oe, result);
        end
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            start = (i == 0);
            tick();
            start = 1'b0;
            if ({busy, result_oe, result} !== {2'b11, 8'h30}) bad = 1'b1;
        end
        compared++;
        if (bad !== 1'b0) begin
            mismatched++;
            $display("FAIL b2b_hold_stable: got oe=%b %h want oe=1 30", result_oe, result);
        end
        ack = 1'b1; start = 1'b1;
        tick();
        ack = 1'b0; start = 1'b0;
        compared++;
        if (st() !== {3'b000, 8'h00, 3'b000}) begin
            mismatched++;
            $display("FAIL b2b_ack_with_start: got %h want %h", st(), {3'b000, 8'h00, 3'b000});
        end
        tick();
        compared++;
        if ({busy, result_oe} !== 2'b00) begin
            mismatched++;
            $display("FAIL b2b_start_dropped: got busy=%b oe=%b want 00", busy, result_oe);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic seen;
        fn = 3'b001; b = 8'h0F; start = 1'b1;
        tick();
        start = 1'b0;
        #1 rst = 1'b1;
        #1;
        compared++;
        if (st() !== 14'h0000) begin
            mismatched++;
            $display("FAIL reset_async: got %h want %h", st(), 14'h0000);
        end
        tick();
        tick();
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (result_oe || busy) seen = 1'b1;
        end
        compared++;
        if (seen !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_abort: got activity=%b want 0", seen);
        end
        rst = 1'b1;
        #2 rst = 1'b0;
        issue(3'b001, 8'h0F, 8'h00, lat);
        compared++;
        if (lat !== LAT) begin
            mismatched++;
            $display("FAIL post_reset_latency: got %0d want %0d", lat, LAT);
        end
        compared++;
        if (st() !== {3'b111, 8'h10, 3'b000}) begin
            mismatched++;
            $display("FAIL post_reset_inc: got %h want %h", st(), {3'b111, 8'h10, 3'b000});
        end
        do_ack();
    endtask

    initial begin
        test_reset();
        test_add_sign();
        test_add_carry();
        test_shl_xor();
        test_functions();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
